demux_reg: RTL and testbench

//   Registered 1-to-4 stream demultiplexer: the distributing counterpart of the
//   4:1 registered mux. Routes one input stream to one of four output channels

---
 rtl/demux_reg_if.sv | 57 +++++
 rtl/demux_reg.sv | 101 ++++++++++
 tb/tb_demux_reg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/demux_reg_if.sv
// ----------------------------------------------------------------------------
// demux_reg_if
//   Bundles the stream-side signals of the registered 1-to-4 demultiplexer.
//   The input stream has one valid/ready pair. Each of the four output
//   channels has its own valid/ready pair and data lane, plus a beat counter.
//
//   Signals
//     in_data    WIDTH      input payload
//     in_valid   1          input beat offered
//     in_ready   1          input beat can be taken this cycle
//     sel        2          destination channel 0..3, sampled only on accept
//     out_data   4*WIDTH    channel k at [k*WIDTH +: WIDTH]
//     out_valid  4          channel k holds a beat
//     out_ready  4          channel k consumer takes the beat
//     beat_cnt   4*CNT_W    accepted beats for channel k at [k*CNT_W +: CNT_W]
//
//   Modports
//     slave   the demultiplexer side
//     master  the producer/consumer side that drives the demultiplexer
// ----------------------------------------------------------------------------
interface demux_reg_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);

    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         sel;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] beat_cnt;

    modport slave (
        input  in_data,
        input  in_valid,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output beat_cnt
    );

    modport master (
        output in_data,
        output in_valid,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  beat_cnt
    );

endinterface

// File: rtl/demux_reg.sv
// ----------------------------------------------------------------------------
// demux_reg
//   Registered 1-to-4 stream demultiplexer. One input stream is routed to one
//   of four output channels chosen by sel. Each channel owns a one-entry
//   output register with its own valid/ready handshake, so a stalled channel
//   only blocks beats that are aimed at it. Each channel also counts the beats
//   it has accepted (wrapping) for bring-up and debug.
//
//   Parameters
//     WIDTH   data width of the input and of each output channel
//     CNT_W   width of each per-channel accepted-beat counter
//
//   Ports
//     clk     single clock, all state updates on the rising edge
//     rst     synchronous reset, active-high; clears slots, valids, counters
//     bus     demux_reg_if.slave: input stream, four output channels and
//             the packed beat counters
// ----------------------------------------------------------------------------
module demux_reg #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    demux_reg_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] slot_q  [4];
    logic [CNT_W-1:0] cnt_q   [4];

    logic             accept;
    logic [3:0]       accept_vec;
    logic [3:0]       drain_vec;

    // The only combinational path: the selected channel can take a beat if it
    // is empty or is being drained in this same cycle (back-to-back).
    assign bus.in_ready = !rst &&
                          ((state_q[bus.sel] == EMPTY) || bus.out_ready[bus.sel]);

    assign accept     = bus.in_valid && bus.in_ready;
    assign accept_vec = accept ? (4'b0001 << bus.sel) : 4'b0000;

    // Per-channel next state. A drain and an accept on the same edge keep the
    // channel FULL, which is what gives one beat per cycle through a channel.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k]   = state_q[k];
            drain_vec[k] = (state_q[k] == FULL) && bus.out_ready[k];
            case (state_q[k])
                EMPTY: begin
                    if (accept_vec[k]) begin
                        state_d[k] = FULL;
                    end
                end
                FULL: begin
                    if (drain_vec[k] && !accept_vec[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: begin
                    state_d[k] = EMPTY;
                end
            endcase
        end
    end

    // State, payload and counter registers. Slots are only written on accept,
    // so a drained channel keeps showing its last payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                slot_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                if (accept_vec[k]) begin
                    slot_q[k] <= bus.in_data;
                    cnt_q[k]  <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Pack the per-channel registers onto the flat output lanes.
    for (genvar k = 0; k < 4; k++) begin : g_pack
        assign bus.out_data[k*WIDTH +: WIDTH] = slot_q[k];
        assign bus.out_valid[k]               = (state_q[k] == FULL);
        assign bus.beat_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

endmodule

// File: tb/tb_demux_reg.sv
// ----------------------------------------------------------------------------
// tb_demux_reg
//   Self-checking bench for demux_reg. A reference model tracks each
//   channel's valid flag and beat counter; accepted payloads are pushed into
//   per-channel expectation queues and popped when the channel drains.
// ----------------------------------------------------------------------------
module tb_demux_reg;

    localparam int WIDTH = 1;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_count  = 0;
    int miss_count = 0;

    logic             model_valid [4];
    logic [CNT_W-1:0] model_cnt   [4];
    logic [WIDTH-1:0] sb          [4][$];
    logic             last_accept;

    // Counts one comparison and reports it if the DUT disagrees with the model.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs (at the falling edge), checks every output
    // against the model, advances the model across the next rising edge.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [WIDTH-1:0] d, input logic [1:0] s,
                                 input logic [3:0] ordy);
        logic exp_ready;
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.sel       = s;
        bus.out_ready = ordy;
        #1;
        exp_ready = !r && (!model_valid[s] || ordy[s]);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("out_valid%0d", k), 32'(bus.out_valid[k]),
                        32'(model_valid[k]));
            checkOutput($sformatf("beat_cnt%0d", k),
                        32'(bus.beat_cnt[k*CNT_W +: CNT_W]), 32'(model_cnt[k]));
            if (model_valid[k] && sb[k].size() > 0) begin
                checkOutput($sformatf("out_data%0d", k),
                            32'(bus.out_data[k*WIDTH +: WIDTH]), 32'(sb[k][0]));
            end
        end
        last_accept = v && exp_ready;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                model_valid[k] = 1'b0;
                model_cnt[k]   = '0;
                sb[k].delete();
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (model_valid[k] && ordy[k]) begin
                    void'(sb[k].pop_front());
                    model_valid[k] = 1'b0;
                end
            end
            if (last_accept) begin
                sb[s].push_back(d);
                model_valid[s] = 1'b1;
                model_cnt[s]   = model_cnt[s] + CNT_W'(1);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic             v;
        logic [WIDTH-1:0] d;
        logic [1:0]       s;

        for (int k = 0; k < 4; k++) begin
            model_valid[k] = 1'b0;
            model_cnt[k]   = '0;
        end
        last_accept = 1'b0;

        // Reset held for two cycles with a beat offered.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = '1;
        bus.sel       = 2'd1;
        bus.out_ready = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 4'b0000);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(0));
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("rst_beat_cnt", 32'(bus.beat_cnt), 32'(0));

        // Single beat to ch2, consumer not ready.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 4'b0000);
        checkOutput("t2_out_valid", 32'(bus.out_valid), 32'(4'b0100));
        checkOutput("t2_data2", 32'(bus.out_data[2*WIDTH +: WIDTH]), 32'(1));
        checkOutput("t2_cnt2", 32'(bus.beat_cnt[2*CNT_W +: CNT_W]), 32'(1));

        // ch2 stalled: input aimed at it waits, then is redirected to ch0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 4'b0000);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b0000);
        checkOutput("t3_out_valid", 32'(bus.out_valid), 32'(4'b0101));

        // Streaming into ch3 with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, WIDTH'(i), 2'd3, 4'b1000);
        end
        checkOutput("t4_cnt3", 32'(bus.beat_cnt[3*CNT_W +: CNT_W]), 32'(8));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd3, 4'b1000);

        // 256 beats into ch1: its counter wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, WIDTH'(i >> 1), 2'd1, 4'b0010);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd1, 4'b0010);
        checkOutput("t5_cnt1_wrap", 32'(bus.beat_cnt[1*CNT_W +: CNT_W]), 32'(0));
        checkOutput("t5_cnt3_kept", 32'(bus.beat_cnt[3*CNT_W +: CNT_W]), 32'(8));

        // Fill ch0 (already full) and ch1, then a one-cycle reset.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 4'b0000);
        checkOutput("t6_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("t6_beat_cnt", 32'(bus.beat_cnt), 32'(0));
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'b0000);
        checkOutput("t6_post_beat", 32'(bus.out_valid), 32'(4'b0001));

        // Random traffic; the source holds data and sel while stalled.
        v = 1'b0;
        d = '0;
        s = 2'd0;
        for (int i = 0; i < 200; i++) begin
            if (!(v && !last_accept)) begin
                v = 1'($urandom_range(0, 1));
                d = WIDTH'($urandom);
                s = 2'($urandom_range(0, 3));
            end
            applyStimulus(1'b0, v, d, s, 4'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
